dvp_tx_gen: RTL and testbench

//  DVP transmitter: the camera-side end of the DVP link our RX controller captures. It converts a

---
 rtl/dvp_tx_gen.sv | 255 +++++++++++++++++++++++++
 tb/tb_dvp_tx_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_tx_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dvp_tx_gen
//   Camera-side DVP transmitter. It turns a valid/ready byte stream into
//   PCLK/VSYNC/HSYNC/HREF/D with fixed, parameterised frame timing. It is used
//   as an on-chip camera emulator for loopback tests and for driving
//   DVP-input peripherals.
//
//   Frame layout, in PCLK periods:
//     VS (vsync=1, VS_PULSE) -> VBP (VS_BP)
//     -> IMG_H x [ HS (hsync=1, HS_PULSE) -> HBP (H_BP) -> ACT (href=1, IMG_W) -> HFP (H_FP) ]
//     -> VFP (V_FP) -> frame_done_o pulse, then the next frame or IDLE
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   tx_start_i   in   level: keep generating frames while high (sampled at frame end)
//   pxl_i        in   byte to transmit
//   pxl_vld_i    in   pxl_i valid
//   pxl_rdy_o    out  byte accepted this cycle when pxl_vld_i & pxl_rdy_o
//   dvp_pclk_o   out  pixel clock, registered, 50% duty
//   dvp_d_o      out  pixel data
//   dvp_href_o   out  line active
//   dvp_vsync_o  out  frame sync, active high
//   dvp_hsync_o  out  line sync, active high
//   frame_done_o out  one-cycle pulse at the end of the vertical front porch
//   underrun_o   out  one-cycle pulse: an active byte was launched with pxl_vld_i low
// -----------------------------------------------------------------------------
module dvp_tx_gen #(
  parameter int DVP_DATA_W = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int PCLK_HALF  = 2,
  parameter int VS_PULSE   = 4,
  parameter int VS_BP      = 8,
  parameter int HS_PULSE   = 4,
  parameter int H_BP       = 2,
  parameter int H_FP       = 2,
  parameter int V_FP       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_start_i,
  input  logic [DVP_DATA_W-1:0] pxl_i,
  input  logic                  pxl_vld_i,
  output logic                  pxl_rdy_o,
  output logic                  dvp_pclk_o,
  output logic [DVP_DATA_W-1:0] dvp_d_o,
  output logic                  dvp_href_o,
  output logic                  dvp_vsync_o,
  output logic                  dvp_hsync_o,
  output logic                  frame_done_o,
  output logic                  underrun_o
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DIV_W  = $clog2(max2(PCLK_HALF, 2));
  localparam int COL_W  = $clog2(max2(IMG_W, 2));
  localparam int LINE_W = $clog2(max2(IMG_H, 2));
  // One phase counter serves every timed state, so size it for the longest.
  localparam int PH_MAX = max2(max2(max2(VS_PULSE, VS_BP), max2(HS_PULSE, H_BP)),
                               max2(max2(H_FP, V_FP), 2));
  localparam int PH_W   = $clog2(PH_MAX);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PCLK_HALF - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMG_H - 1);
  localparam logic [PH_W-1:0]   VS_LAST   = PH_W'(VS_PULSE - 1);
  localparam logic [PH_W-1:0]   VBP_LAST  = PH_W'(VS_BP - 1);
  localparam logic [PH_W-1:0]   HS_LAST   = PH_W'(HS_PULSE - 1);
  localparam logic [PH_W-1:0]   HBP_LAST  = PH_W'(H_BP - 1);
  localparam logic [PH_W-1:0]   HFP_LAST  = PH_W'(H_FP - 1);
  localparam logic [PH_W-1:0]   VFP_LAST  = PH_W'(V_FP - 1);

  // S_PRE lets the divider run for one PCLK period before the first VS period
  // is driven, so the frame starts on a clean falling edge of PCLK.
  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_VS, S_VBP, S_HS, S_HBP, S_ACT, S_HFP, S_VFP
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    pclk_q, pclk_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic [DVP_DATA_W-1:0]   data_q, data_d;
  logic                    href_q, href_d;
  logic                    vsync_q, vsync_d;
  logic                    hsync_q, hsync_d;
  logic                    done_q, done_d;
  logic                    urun_q, urun_d;

  logic                    fall_tick;
  logic [PH_W-1:0]         phase_lim;
  logic                    phase_end;

  // Last phase value of the state currently being driven.
  always_comb begin
    phase_lim = '0;
    case (state_q)
      S_VS:    phase_lim = VS_LAST;
      S_VBP:   phase_lim = VBP_LAST;
      S_HS:    phase_lim = HS_LAST;
      S_HBP:   phase_lim = HBP_LAST;
      S_HFP:   phase_lim = HFP_LAST;
      S_VFP:   phase_lim = VFP_LAST;
      default: phase_lim = '0;
    endcase
  end

  assign phase_end = (phase_q == phase_lim);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pclk_d    = pclk_q;
    phase_d   = phase_q;
    col_d     = col_q;
    line_d    = line_q;
    data_d    = data_q;
    href_d    = href_q;
    vsync_d   = vsync_q;
    hsync_d   = hsync_q;
    done_d    = 1'b0;
    urun_d    = 1'b0;
    fall_tick = 1'b0;
    pxl_rdy_o = 1'b0;

    // PCLK divider: parked at 0 in IDLE, free-running otherwise.
    if (state_q == S_IDLE) begin
      div_d  = '0;
      pclk_d = 1'b0;
      if (tx_start_i) begin
        state_d = S_PRE;
      end
    end else begin
      if (div_q == DIV_LAST) begin
        div_d     = '0;
        pclk_d    = ~pclk_q;
        fall_tick = pclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    // Everything visible on the DVP side moves only when PCLK falls, so it is
    // stable around the following PCLK rising edge where the receiver samples.
    if (fall_tick) begin
      case (state_q)
        S_PRE: state_d = S_VS;
        S_VS:  if (phase_end) state_d = S_VBP;
        S_VBP: if (phase_end) state_d = S_HS;
        S_HS:  if (phase_end) state_d = S_HBP;
        S_HBP: begin
          if (phase_end) begin
            state_d = S_ACT;
            col_d   = '0;
          end
        end
        S_ACT: begin
          if (col_q == COL_LAST) begin
            state_d = S_HFP;
            col_d   = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        S_HFP: begin
          if (phase_end) begin
            if (line_q == LINE_LAST) begin
              state_d = S_VFP;
              line_d  = '0;
            end else begin
              state_d = S_HS;
              line_d  = line_q + 1'b1;
            end
          end
        end
        S_VFP: begin
          if (phase_end) begin
            done_d  = 1'b1;
            // tx_start_i is only looked at here, so a frame always completes.
            state_d = tx_start_i ? S_VS : S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Phase restarts on every state change; ACT is timed by the column count.
      if (state_d != state_q) begin
        phase_d = '0;
      end else if (state_q != S_ACT) begin
        phase_d = phase_q + 1'b1;
      end

      // Register the outputs of the period that starts now.
      vsync_d = (state_d == S_VS);
      hsync_d = (state_d == S_HS);
      href_d  = (state_d == S_ACT);
      data_d  = '0;
      if (state_d == S_ACT) begin
        // HREF never stalls: a missing byte goes out as zero and is flagged.
        pxl_rdy_o = 1'b1;
        if (pxl_vld_i) begin
          data_d = pxl_i;
        end else begin
          urun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      pclk_q  <= 1'b0;
      phase_q <= '0;
      col_q   <= '0;
      line_q  <= '0;
      data_q  <= '0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pclk_q  <= pclk_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      line_q  <= line_d;
      data_q  <= data_d;
      href_q  <= href_d;
      vsync_q <= vsync_d;
      hsync_q <= hsync_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
    end
  end

  assign dvp_pclk_o   = pclk_q;
  assign dvp_d_o      = data_q;
  assign dvp_href_o   = href_q;
  assign dvp_vsync_o  = vsync_q;
  assign dvp_hsync_o  = hsync_q;
  assign frame_done_o = done_q;
  assign underrun_o   = urun_q;

endmodule

// File: tb/tb_dvp_tx_gen.sv
`timescale 1ns/1ps
// Bench for dvp_tx_gen: two instances (PCLK_HALF=1 and PCLK_HALF=3) share the
// stimulus. A period-level reference derives every output from the frame
// geometry; hand-computed literals pin the reference itself.
module tb_dvp_tx_gen;
  localparam int IW = 4, IH = 2, VSP = 2, VBP = 2, HSP = 2, HBP = 1, HFP = 1, VFP = 2;
  localparam int LINE  = HSP + HBP + IW + HFP;          // 8 periods
  localparam int FRAME = VSP + VBP + IH * LINE + VFP;   // 22 periods

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic       pxl_vld = 1'b0;
  logic [7:0] pxl_i = 8'h00;

  logic       rdy0, pclk0, href0, vs0, hs0, fd0, ur0;
  logic [7:0] d0;
  logic       rdy1, pclk1, href1, vs1, hs1, fd1, ur1;
  logic [7:0] d1;

  dvp_tx_gen #(.DVP_DATA_W(8), .IMG_W(IW), .IMG_H(IH), .PCLK_HALF(1), .VS_PULSE(VSP),
               .VS_BP(VBP), .HS_PULSE(HSP), .H_BP(HBP), .H_FP(HFP), .V_FP(VFP)) dut0 (
    .clk(clk), .rst(rst), .tx_start_i(tx_start), .pxl_i(pxl_i), .pxl_vld_i(pxl_vld),
    .pxl_rdy_o(rdy0), .dvp_pclk_o(pclk0), .dvp_d_o(d0), .dvp_href_o(href0),
    .dvp_vsync_o(vs0), .dvp_hsync_o(hs0), .frame_done_o(fd0), .underrun_o(ur0));

  dvp_tx_gen #(.DVP_DATA_W(8), .IMG_W(IW), .IMG_H(IH), .PCLK_HALF(3), .VS_PULSE(VSP),
               .VS_BP(VBP), .HS_PULSE(HSP), .H_BP(HBP), .H_FP(HFP), .V_FP(VFP)) dut1 (
    .clk(clk), .rst(rst), .tx_start_i(tx_start), .pxl_i(pxl_i), .pxl_vld_i(pxl_vld),
    .pxl_rdy_o(rdy1), .dvp_pclk_o(pclk1), .dvp_d_o(d1), .dvp_href_o(href1),
    .dvp_vsync_o(vs1), .dvp_hsync_o(hs1), .frame_done_o(fd1), .underrun_o(ur1));

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  int         m_run [2];
  int         m_t   [2];
  bit         e_pclk[2], e_vs[2], e_hs[2], e_href[2], e_fd[2], e_ur[2], e_rdy[2];
  logic [7:0] e_d   [2];

  // ---------------- bench bookkeeping ----------------
  int         n_vec = 0, n_err = 0, cyc = 0;
  int         vld_mode = 0, rdy_cnt = 0;
  logic [7:0] src_mem [256];
  logic [7:0] src_idx = 8'h00;
  logic       rdy_n = 1'b0;
  logic [7:0] got_d [$];
  int         fd_cnt = 0, fd1_cnt = 0, ur_cnt = 0, flen = -1, vs_rise_cyc = 0, hi1 = 0;
  logic       prev_pclk0 = 1'b0, prev_pclk1 = 1'b0, prev_vs0 = 1'b0;
  bit         seen_fall0 = 1'b0, first_vs0 = 1'b0;
  logic [7:0] exp3 [8] = '{8'h10, 8'h11, 8'h00, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};

  // Classify period p of a frame: 0 blank, 1 VSYNC, 2 HSYNC, 3 active.
  function automatic int kind(input int p);
    int q, r;
    if (p < VSP) return 1;
    if (p < VSP + VBP) return 0;
    q = p - VSP - VBP;
    if (q >= IH * LINE) return 0;
    r = q % LINE;
    if (r < HSP) return 2;
    if (r < HSP + HBP) return 0;
    if (r < HSP + HBP + IW) return 3;
    return 0;
  endfunction

  // Advance instance k's reference by one clk edge. m_t counts clk edges since
  // the start request was taken; PCLK falls every 2*ph edges and each fall
  // starts global period g = m_t/(2*ph) - 1.
  task automatic model_step(input int k);
    int ph, g, p;
    ph = (k == 0) ? 1 : 3;
    e_fd[k] = 1'b0;
    e_ur[k] = 1'b0;
    if (rst) begin
      m_run[k] = 0; m_t[k] = 0;
      e_pclk[k] = 1'b0; e_vs[k] = 1'b0; e_hs[k] = 1'b0; e_href[k] = 1'b0; e_d[k] = 8'h00;
    end else if (m_run[k] == 0) begin
      if (tx_start) begin
        m_run[k] = 1; m_t[k] = 0;
      end
    end else begin
      m_t[k]++;
      e_pclk[k] = ((m_t[k] / ph) % 2) == 1;
      if (m_t[k] % (2 * ph) == 0) begin
        g = m_t[k] / (2 * ph) - 1;
        p = g % FRAME;
        if (g > 0 && p == 0) begin
          e_fd[k] = 1'b1;
          if (!tx_start) m_run[k] = 0;
        end
        e_vs[k]   = (m_run[k] != 0) && (kind(p) == 1);
        e_hs[k]   = (m_run[k] != 0) && (kind(p) == 2);
        e_href[k] = (m_run[k] != 0) && (kind(p) == 3);
        e_d[k]    = 8'h00;
        if (e_href[k]) begin
          if (pxl_vld) e_d[k] = pxl_i;
          else         e_ur[k] = 1'b1;
        end
      end
    end
    e_rdy[k] = 1'b0;
    if (!rst && m_run[k] != 0 && ((m_t[k] + 1) % (2 * ph)) == 0)
      e_rdy[k] = (kind(((m_t[k] + 1) / (2 * ph) - 1) % FRAME) == 3);
  endtask

  function automatic logic [14:0] dut_vec(input int k);
    if (k == 0) return {pclk0, vs0, hs0, href0, d0, fd0, ur0, rdy0};
    return {pclk1, vs1, hs1, href1, d1, fd1, ur1, rdy1};
  endfunction

  function automatic logic [14:0] exp_vec(input int k);
    return {e_pclk[k], e_vs[k], e_hs[k], e_href[k], e_d[k], e_fd[k], e_ur[k], e_rdy[k]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances, plus observations for the literals.
  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (dut_vec(k) !== exp_vec(k)) begin
        n_err++;
        $display("FAIL dvp%0d cycle %0d: got {pclk,vs,hs,href,d,fd,ur,rdy}=%h required %h",
                 k, cyc, dut_vec(k), exp_vec(k));
      end
    end
    if (prev_pclk0 && !pclk0) begin
      if (!seen_fall0) begin
        seen_fall0 = 1'b1;
        first_vs0  = vs0;
      end
      if (href0) begin
        got_d.push_back(d0);
        $display("byte %0d: d=%h", got_d.size() - 1, d0);
      end
    end
    prev_pclk0 = pclk0;
    if (vs0 && !prev_vs0) vs_rise_cyc = cyc;
    prev_vs0 = vs0;
    if (fd0) begin
      fd_cnt++;
      flen = cyc - vs_rise_cyc;
    end
    if (ur0) ur_cnt++;
    if (fd1) fd1_cnt++;
    if (pclk1) begin
      hi1++;
    end else begin
      if (prev_pclk1 && !rst) check("pclk_half3_high_width", hi1, 3);
      hi1 = 0;
    end
    prev_pclk1 = pclk1;
  endtask

  task automatic tick();
    @(negedge clk);
    case (vld_mode)
      0:       pxl_vld = 1'b1;
      1:       pxl_vld = ($urandom_range(0, 3) != 0);
      default: pxl_vld = !(rdy0 && rdy_cnt == 2);
    endcase
    if (rdy0) rdy_cnt++;
    pxl_i = src_mem[src_idx];
    rdy_n = rdy0;
    @(posedge clk);
    cyc++;
    model_step(0);
    model_step(1);
    if (pxl_vld && rdy_n) src_idx++;
    #1;
    compare_all();
  endtask

  task automatic reset_counts();
    got_d.delete();
    fd_cnt = 0; fd1_cnt = 0; ur_cnt = 0; rdy_cnt = 0; flen = -1;
    src_idx = 8'h00;
    seen_fall0 = 1'b0; first_vs0 = 1'b0;
  endtask

  initial begin
    int w;
    for (int i = 0; i < 256; i++) src_mem[i] = 8'h10 + 8'(i);
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_t[k] = 0; e_pclk[k] = 0; e_vs[k] = 0; e_hs[k] = 0;
      e_href[k] = 0; e_fd[k] = 0; e_ur[k] = 0; e_rdy[k] = 0; e_d[k] = 8'h00;
    end

    // Reset state
    repeat (3) tick();
    check("reset_outputs_dvp0", int'(dut_vec(0)), 0);
    check("reset_outputs_dvp1", int'(dut_vec(1)), 0);
    rst = 1'b0;
    repeat (2) tick();

    // One frame, source always valid; tx_start dropped during line 0
    reset_counts();
    vld_mode = 0;
    tx_start = 1'b1;
    repeat (18) tick();
    tx_start = 1'b0;
    repeat (160) tick();
    check("frame1_byte_count", got_d.size(), 8);
    for (int i = 0; i < 8 && i < got_d.size(); i++) check("frame1_byte", int'(got_d[i]), 16 + i);
    check("frame1_done_pulses", fd_cnt, 1);
    check("frame1_underruns", ur_cnt, 0);
    check("frame1_clk_len", flen, 44);
    check("frame1_done_pulses_half3", fd1_cnt, 1);
    check("idle_pclk_parked", int'(pclk0), 0);
    check("idle_vsync", int'(vs0), 0);

    // Withheld 3rd byte of line 0
    reset_counts();
    vld_mode = 2;
    tx_start = 1'b1;
    repeat (18) tick();
    tx_start = 1'b0;
    repeat (160) tick();
    check("underrun_byte_count", got_d.size(), 8);
    for (int i = 0; i < 8 && i < got_d.size(); i++) check("underrun_byte", int'(got_d[i]), int'(exp3[i]));
    check("underrun_pulses", ur_cnt, 1);
    check("underrun_done_pulses", fd_cnt, 1);

    // Random source gaps, random data, occasional tx_start toggles
    reset_counts();
    vld_mode = 1;
    for (int i = 0; i < 256; i++) src_mem[i] = 8'($urandom);
    tx_start = 1'b1;
    repeat (900) begin
      if ($urandom_range(0, 59) == 0) tx_start = ~tx_start;
      tick();
    end
    tx_start = 1'b0;
    repeat (200) tick();
    check("random_slots_per_frame", got_d.size(), 8 * fd_cnt);

    // Reset asserted during an active period
    for (int i = 0; i < 256; i++) src_mem[i] = 8'h10 + 8'(i);
    reset_counts();
    vld_mode = 0;
    tx_start = 1'b1;
    w = 0;
    while (!href0 && w < 100) begin
      tick();
      w++;
    end
    check("reached_active", int'(href0), 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_dvp0", int'(dut_vec(0)), 0);
    check("async_reset_dvp1", int'(dut_vec(1)), 0);
    repeat (3) tick();
    rst = 1'b0;
    reset_counts();
    repeat (30) tick();
    tx_start = 1'b0;
    repeat (160) tick();
    check("restart_first_period_vsync", int'(first_vs0), 1);
    check("restart_byte_count", got_d.size(), 8);
    for (int i = 0; i < 8 && i < got_d.size(); i++) check("restart_byte", int'(got_d[i]), 16 + i);
    check("restart_done_pulses", fd_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
